l2_cache: RTL and testbench

L2_CACHE -- requirements
Module: l2_cache

---
 rtl/l2_cache_pkg.sv | 30 +++
 rtl/l2_line_array.sv | 53 +++++
 rtl/l2_cache.sv | 171 +++++++++++++++++
 tb/tb_l2_cache.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared constants, state encoding and word helpers for l2_cache
package l2_cache_pkg;

  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int ADDR_W     = 30;
  localparam int MEM_ADDR_W = 28;
  localparam int OFFSET_LSB = 0;
  localparam int INDEX_LSB  = 2;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_ALLOCATE  = 2'd2;
  localparam logic [1:0] ST_RESPOND   = 2'd3;

  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] line,
                                                 input logic [1:0] off);
    return line[off*WORD_W +: WORD_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] line,
                                                    input logic [1:0] off,
                                                    input logic [WORD_W-1:0] w);
    logic [BLOCK_W-1:0] r;
    r = line;
    r[off*WORD_W +: WORD_W] = w;
    return r;
  endfunction

endpackage

// File: rtl/l2_line_array.sv
// rtl/l2_line_array.sv - direct-mapped line storage, one combinational read port, one write port
module l2_line_array
  import l2_cache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 28 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_valid,
  input  logic               wr_dirty,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [BLOCK_W-1:0] data_q [SETS];

  // Only the status bits need reset; tag/data are meaningless while valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_valid;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/l2_cache.sv
// rtl/l2_cache.sv - direct-mapped write-back L2 cache; optional L2_PERF_CNT_EN adds hit/miss counters
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int INDEX_W = 6
) (
  input  logic                  clk,
  input  logic                  proc_reset_n,
  input  logic                  L1_read,
  input  logic                  L1_write,
  input  logic [ADDR_W-1:0]     L1_addr,
  input  logic [WORD_W-1:0]     L1_wdata,
  output logic [WORD_W-1:0]     L1_rdata,
  output logic                  L1_ready,
  output logic [BLOCK_W-1:0]    L1_block_rdata,
  output logic                  L1_block_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0]    mem_wdata,
  input  logic [BLOCK_W-1:0]    mem_rdata,
  input  logic                  mem_ready
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int TAG_W   = ADDR_W - INDEX_LSB - INDEX_W;
  localparam int TAG_LSB = INDEX_LSB + INDEX_W;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               is_write_q;
  logic               start_miss;

  logic [1:0]         l1_off, q_off;
  logic [INDEX_W-1:0] l1_index, q_index, rd_index;
  logic [TAG_W-1:0]   l1_tag, q_tag;
  logic               rd_valid, rd_dirty, hit, req;
  logic [TAG_W-1:0]   rd_tag;
  logic [BLOCK_W-1:0] rd_data;

  logic               wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]   wr_tag;
  logic [BLOCK_W-1:0] wr_data;

  assign l1_off   = L1_addr[OFFSET_LSB +: 2];
  assign l1_index = L1_addr[INDEX_LSB +: INDEX_W];
  assign l1_tag   = L1_addr[TAG_LSB +: TAG_W];
  assign q_off    = addr_q[OFFSET_LSB +: 2];
  assign q_index  = addr_q[INDEX_LSB +: INDEX_W];
  assign q_tag    = addr_q[TAG_LSB +: TAG_W];

  // Outside IDLE the array is addressed by the latched miss, not by L1.
  assign rd_index = (state_q == ST_IDLE) ? l1_index : q_index;
  assign req      = L1_read | L1_write;
  assign hit      = rd_valid && (rd_tag == l1_tag);

  l2_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_lines (
    .clk      (clk),
    .rst_n    (proc_reset_n),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (rd_index),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_comb begin
    state_d        = state_q;
    start_miss     = 1'b0;
    L1_rdata       = '0;
    L1_ready       = 1'b0;
    L1_block_rdata = '0;
    L1_block_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    wr_en          = 1'b0;
    wr_valid       = 1'b1;
    wr_dirty       = 1'b0;
    wr_tag         = rd_tag;
    wr_data        = rd_data;
    case (state_q)
      ST_IDLE: begin
        if (req && hit) begin
          L1_ready = 1'b1;
          if (L1_write) begin
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = merge_word(rd_data, l1_off, L1_wdata);
          end else begin
            L1_rdata = get_word(rd_data, l1_off);
          end
        end else if (req) begin
          start_miss = 1'b1;
          state_d    = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {rd_tag, q_index};
        mem_wdata = rd_data;
        if (mem_ready) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {q_tag, q_index};
        if (mem_ready) begin
          wr_en   = 1'b1;
          wr_tag  = q_tag;
          wr_data = mem_rdata;
          state_d = ST_RESPOND;
        end
      end
      default: begin
        L1_ready       = 1'b1;
        L1_block_valid = 1'b1;
        if (is_write_q) begin
          wr_en          = 1'b1;
          wr_dirty       = 1'b1;
          wr_data        = merge_word(rd_data, q_off, wdata_q);
          L1_block_rdata = wr_data;
        end else begin
          L1_rdata       = get_word(rd_data, q_off);
          L1_block_rdata = rd_data;
        end
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_miss) begin
        addr_q     <= L1_addr;
        wdata_q    <= L1_wdata;
        is_write_q <= L1_write;
      end
    end
  end

`ifdef L2_PERF_CNT_EN
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (state_q == ST_IDLE && req && hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      if (state_q == ST_RESPOND && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache.sv
// tb/tb_l2_cache.sv - vector-table bench for l2_cache (counter checks when L2_PERF_CNT_EN is defined)
module tb_l2_cache;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         L1_read, L1_write;
  logic [29:0]  L1_addr;
  logic [31:0]  L1_wdata, L1_rdata;
  logic         L1_ready;
  logic [127:0] L1_block_rdata;
  logic         L1_block_valid;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
`ifdef L2_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  l2_cache dut (
    .clk            (clk),
    .proc_reset_n   (proc_reset_n),
    .L1_read        (L1_read),
    .L1_write       (L1_write),
    .L1_addr        (L1_addr),
    .L1_wdata       (L1_wdata),
    .L1_rdata       (L1_rdata),
    .L1_ready       (L1_ready),
    .L1_block_rdata (L1_block_rdata),
    .L1_block_valid (L1_block_valid),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rd, wr;
    logic [29:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] mrdata;
    logic         mready;
    logic         e_ready;
    logic [31:0]  e_rdata;
    logic         e_bvalid;
    logic [127:0] e_block;
    logic         e_mrd, e_mwr;
    logic [27:0]  e_maddr;
    logic [127:0] e_mwdata;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_hits = 0;
  int   exp_miss = 0;

  localparam logic [127:0] LINE_L = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_M = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] LINE_X = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] LINE_D = 128'h44444444_12345678_DEADBEEF_11111111;
  localparam logic [127:0] LINE_C = 128'hCAFEF00D_33333333_22222222_11111111;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [29:0] addr,
                     input logic [31:0] wd, input logic [127:0] mrd, input logic mrdy,
                     input logic e_ready, input logic [31:0] e_rdata, input logic e_bv,
                     input logic [127:0] e_blk, input logic e_mrd, input logic e_mwr,
                     input logic [27:0] e_maddr, input logic [127:0] e_mwd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wd; v.mrdata = mrd; v.mready = mrdy;
    v.e_ready = e_ready; v.e_rdata = e_rdata; v.e_bvalid = e_bv; v.e_block = e_blk;
    v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_maddr = e_maddr; v.e_mwdata = e_mwd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [29:0] addr,
                       input logic [31:0] wd, input logic [127:0] mrd, input logic mrdy);
    L1_read = rd; L1_write = wr; L1_addr = addr; L1_wdata = wd;
    mem_rdata = mrd; mem_ready = mrdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    proc_reset_n = 1'b0;
    drive(1'b1, 1'b0, 30'h40, 32'h0, LINE_X, 1'b1);
    next_cycle();
    #3;
    chk("reset_ready", {127'b0, L1_ready}, 128'd0);
    chk("reset_mem_read", {127'b0, mem_read}, 128'd0);
    chk("reset_mem_addr", {100'b0, mem_addr}, 128'd0);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, '0, 1'b0);
    proc_reset_n = 1'b1;

    //  rd   wr   addr      wdata         mem_rdata mrdy | ready rdata        bv   block   mrd  mwr  maddr     mwdata
    add(1'b0,1'b0,30'h000,  32'h0,        '0,     1'b0,  1'b0,32'h0,        1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b1,1'b0,30'h040,  32'h0,        LINE_X, 1'b1,  1'b0,32'h0,        1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b0,1'b0,30'h000,  32'h0,        '0,     1'b0,  1'b0,32'h0,        1'b0,'0,     1'b1,1'b0,28'h10,   '0);
    add(1'b0,1'b0,30'h000,  32'h0,        LINE_L, 1'b1,  1'b0,32'h0,        1'b0,'0,     1'b1,1'b0,28'h10,   '0);
    add(1'b0,1'b0,30'h000,  32'h0,        '0,     1'b0,  1'b1,32'h11111111, 1'b1,LINE_L, 1'b0,1'b0,28'h00,   '0);
    add(1'b1,1'b0,30'h042,  32'h0,        '0,     1'b0,  1'b1,32'h33333333, 1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b0,1'b1,30'h041,  32'hDEADBEEF, '0,     1'b0,  1'b1,32'h0,        1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b1,1'b0,30'h041,  32'h0,        '0,     1'b0,  1'b1,32'hDEADBEEF, 1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b1,1'b1,30'h042,  32'h12345678, '0,     1'b0,  1'b1,32'h0,        1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b1,1'b0,30'h042,  32'h0,        '0,     1'b0,  1'b1,32'h12345678, 1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b1,1'b0,30'h140,  32'h0,        '0,     1'b0,  1'b0,32'h0,        1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b0,1'b0,30'h000,  32'h0,        '0,     1'b0,  1'b0,32'h0,        1'b0,'0,     1'b0,1'b1,28'h10,   LINE_D);
    add(1'b0,1'b0,30'h000,  32'h0,        LINE_X, 1'b1,  1'b0,32'h0,        1'b0,'0,     1'b0,1'b1,28'h10,   LINE_D);
    add(1'b0,1'b0,30'h000,  32'h0,        '0,     1'b0,  1'b0,32'h0,        1'b0,'0,     1'b1,1'b0,28'h50,   '0);
    add(1'b0,1'b0,30'h000,  32'h0,        LINE_M, 1'b1,  1'b0,32'h0,        1'b0,'0,     1'b1,1'b0,28'h50,   '0);
    add(1'b0,1'b0,30'h000,  32'h0,        '0,     1'b0,  1'b1,32'h55555555, 1'b1,LINE_M, 1'b0,1'b0,28'h00,   '0);
    add(1'b1,1'b0,30'h143,  32'h0,        '0,     1'b0,  1'b1,32'h88888888, 1'b0,'0,     1'b0,1'b0,28'h00,   '0);
    add(1'b0,1'b0,30'h000,  32'h0,        LINE_X, 1'b1,  1'b0,32'h0,        1'b0,'0,     1'b0,1'b0,28'h00,   '0);

    foreach (vecs[i]) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mrdata, vecs[i].mready);
      #4;
      chk($sformatf("v%0d_ready", i), {127'b0, L1_ready}, {127'b0, vecs[i].e_ready});
      chk($sformatf("v%0d_rdata", i), {96'b0, L1_rdata}, {96'b0, vecs[i].e_rdata});
      chk($sformatf("v%0d_bvalid", i), {127'b0, L1_block_valid}, {127'b0, vecs[i].e_bvalid});
      chk($sformatf("v%0d_block", i), L1_block_rdata, vecs[i].e_block);
      chk($sformatf("v%0d_mem_read", i), {127'b0, mem_read}, {127'b0, vecs[i].e_mrd});
      chk($sformatf("v%0d_mem_write", i), {127'b0, mem_write}, {127'b0, vecs[i].e_mwr});
      chk($sformatf("v%0d_mem_addr", i), {100'b0, mem_addr}, {100'b0, vecs[i].e_maddr});
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
      if (vecs[i].e_ready && !vecs[i].e_bvalid) exp_hits++;
      if (vecs[i].e_bvalid) exp_miss++;
      next_cycle();
    end
    drive(1'b0, 1'b0, 30'h0, 32'h0, '0, 1'b0);
`ifdef L2_PERF_CNT_EN
    #3;
    chk("hit_cnt", {96'b0, hit_cnt}, 128'(exp_hits));
    chk("miss_cnt", {96'b0, miss_cnt}, 128'(exp_miss));
    next_cycle();
`endif

    // Write miss to a clean empty set; request dropped after one cycle.
    drive(1'b0, 1'b1, 30'h083, 32'hCAFEF00D, '0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, '0, 1'b0);
    #3;
    chk("wmiss_mem_read", {127'b0, mem_read}, 128'd1);
    chk("wmiss_mem_addr", {100'b0, mem_addr}, 128'h20);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, LINE_L, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, '0, 1'b0);
    #3;
    chk("wmiss_bvalid", {127'b0, L1_block_valid}, 128'd1);
    chk("wmiss_block", L1_block_rdata, LINE_C);
    chk("wmiss_rdata", {96'b0, L1_rdata}, 128'd0);
    next_cycle();
    drive(1'b1, 1'b0, 30'h083, 32'h0, '0, 1'b0);
    #3;
    chk("wmiss_readback", {96'b0, L1_rdata}, 128'hCAFEF00D);
    next_cycle();

    // Reset while ALLOCATE waits on memory.
    drive(1'b1, 1'b0, 30'h240, 32'h0, '0, 1'b0);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, '0, 1'b0);
    begin
      int waited = 0;
      while (!mem_read && waited < 8) begin
        next_cycle();
        waited++;
      end
      chk("alloc_reached", {127'b0, mem_read}, 128'd1);
      chk("alloc_addr", {100'b0, mem_addr}, 128'h90);
    end
    #1;
    proc_reset_n = 1'b0;
    #1;
    chk("rst_mem_read", {127'b0, mem_read}, 128'd0);
    chk("rst_mem_addr", {100'b0, mem_addr}, 128'd0);
    next_cycle();
    proc_reset_n = 1'b1;
    next_cycle();
    #3;
    chk("no_replay", {127'b0, mem_read}, 128'd0);
    next_cycle();
    drive(1'b1, 1'b0, 30'h040, 32'h0, '0, 1'b0);
    #3;
    chk("post_rst_miss", {127'b0, L1_ready}, 128'd0);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, '0, 1'b0);
    #3;
    chk("post_rst_mem_read", {127'b0, mem_read}, 128'd1);
    chk("post_rst_mem_addr", {100'b0, mem_addr}, 128'h10);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, LINE_L, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 30'h0, 32'h0, '0, 1'b0);
    #3;
    chk("post_rst_rdata", {96'b0, L1_rdata}, 128'h11111111);
    chk("post_rst_bvalid", {127'b0, L1_block_valid}, 128'd1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
